dbg_mem_bridge: RTL and testbench

- Parametrised bridge from the debug module's req/gnt/r_valid master port to the team's stb/we/resp line-based memory bus.
- Replaces the direct tie of gnt and r_valid to a single resp signal.
- Adds request buffering, configurable line width with lane steering, and a bus timeout that returns an error response instead of hanging the debugger.
- Sits between dm_top's master port and the memory arbiter.

---
 rtl/dbg_bridge_pkg.sv | 26 ++
 rtl/dbg_req_fifo.sv | 65 ++++++
 rtl/dbg_mem_bridge.sv | 170 +++++++++++++++++
 tb/tb_dbg_mem_bridge.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dbg_bridge_pkg.sv
// Shared types and helpers for the debug-master to line-memory bridge.
package dbg_bridge_pkg;

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    // Reference request layout for a 32-bit debug port; the bridge builds its
    // own width-matched copy of this struct and hands it to the FIFO.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } dbg_req_t;

    function automatic int unsigned lane_of(input logic [31:0] addr,
                                            input int unsigned data_w,
                                            input int unsigned line_w);
        logic [31:0] offs;
        offs = addr & (line_w / 8 - 1);
        return offs / (data_w / 8);
    endfunction

endpackage

// File: rtl/dbg_req_fifo.sv
// Synchronous request FIFO with wrap-around pointers; exposes the head and the
// entry behind it so the bridge can issue back-to-back transfers.
module dbg_req_fifo
    import dbg_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = dbg_req_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     wdata_i,
    input  logic pop_i,
    output T     head_o,
    output T     next_o,
    output logic full_o,
    output logic empty_o,
    output logic two_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign two_o   = (count_q > CNT_W'(1));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rptr_q];
    assign next_o  = mem_q[ptr_inc(rptr_q)];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= ptr_inc(wptr_q);
            if (do_pop)  rptr_q <= ptr_inc(rptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dbg_mem_bridge.sv
// Bridges the debug module's req/gnt/r_valid master port onto the stb/we/resp
// line memory bus, with request buffering, lane steering and a bus timeout.
module dbg_mem_bridge
    import dbg_bridge_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_W     = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [DATA_W-1:0]     r_rdata_o,
    output logic                  r_err_o,
    output logic                  mem_stb_o,
    output logic                  mem_we_o,
    output logic [LINE_W/8-1:0]   mem_mbe_o,
    output logic [31:0]           mem_address_o,
    output logic [LINE_W-1:0]     mem_wdata_o,
    input  logic                  mem_resp_i,
    input  logic [LINE_W-1:0]     mem_rdata_i,
    output logic                  busy_o
);

    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned MBE_W  = LINE_W / 8;
    localparam int unsigned LANES  = LINE_W / DATA_W;
    localparam int unsigned LANE_B = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [31:0] ALIGN  = 32'(MBE_W - 1);

    typedef struct packed {
        logic              we;
        logic [31:0]       addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LANE_B-1:0] cur_lane_q;
    logic              cur_we_q;

    req_t              in_req, head, next, src;
    logic [LANE_B-1:0] src_lane;
    logic              fifo_full, fifo_empty, fifo_two;
    logic              push, resp_hit, tout_hit, done, load;

    dbg_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (in_req),
        .pop_i   (done),
        .head_o  (head),
        .next_o  (next),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .two_o   (fifo_two)
    );

    assign gnt_o  = !fifo_full;
    assign busy_o = !fifo_empty || (state_q == XFER);

    always_comb begin
        in_req.we    = we_i;
        in_req.addr  = addr_i;
        in_req.be    = be_i;
        in_req.wdata = wdata_i;

        push     = req_i && !fifo_full;
        resp_hit = (state_q == XFER) && mem_resp_i;
        tout_hit = (state_q == XFER) && !mem_resp_i && (cnt_q == CNT_W'(TIMEOUT - 1));
        done     = resp_hit || tout_hit;

        // The entry that becomes head after this cycle may be the one being
        // pushed right now, so it is taken straight from the request port.
        load = 1'b0;
        src  = head;
        if (state_q == IDLE) begin
            if (!fifo_empty) begin
                load = 1'b1;
            end else if (push) begin
                load = 1'b1;
                src  = in_req;
            end
        end else if (done) begin
            if (fifo_two) begin
                load = 1'b1;
                src  = next;
            end else if (push) begin
                load = 1'b1;
                src  = in_req;
            end
        end
        src_lane = LANE_B'(lane_of(src.addr, DATA_W, LINE_W));

        state_d = state_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = XFER;
            cnt_d   = '0;
        end else if (done) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == XFER && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_stb_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_mbe_o     <= '0;
            mem_address_o <= '0;
            mem_wdata_o   <= '0;
            cur_lane_q    <= '0;
            cur_we_q      <= 1'b0;
        end else if (load) begin
            mem_stb_o     <= 1'b1;
            mem_we_o      <= src.we;
            mem_mbe_o     <= MBE_W'(src.be) << (src_lane * BE_W);
            mem_address_o <= src.addr & ~ALIGN;
            mem_wdata_o   <= {LANES{src.wdata}};
            cur_lane_q    <= src_lane;
            cur_we_q      <= src.we;
        end else if (done) begin
            mem_stb_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_mbe_o     <= '0;
            mem_address_o <= '0;
            mem_wdata_o   <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_o <= 1'b0;
            r_err_o   <= 1'b0;
            r_rdata_o <= '0;
        end else begin
            r_valid_o <= done;
            r_err_o   <= tout_hit;
            r_rdata_o <= (resp_hit && !cur_we_q) ?
                         mem_rdata_i[cur_lane_q*DATA_W +: DATA_W] : '0;
        end
    end

endmodule

// File: tb/tb_dbg_mem_bridge.sv
// Directed self-checking bench for dbg_mem_bridge with a 128-bit line.
module tb_dbg_mem_bridge;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LINE_W = 128;
    localparam logic [127:0] LINE_DATA = 128'h44444444_33333333_22222222_11111111;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                req_i;
    logic                we_i;
    logic [31:0]         addr_i;
    logic [3:0]          be_i;
    logic [31:0]         wdata_i;
    logic                gnt_o;
    logic                r_valid_o;
    logic [31:0]         r_rdata_o;
    logic                r_err_o;
    logic                mem_stb_o;
    logic                mem_we_o;
    logic [15:0]         mem_mbe_o;
    logic [31:0]         mem_address_o;
    logic [127:0]        mem_wdata_o;
    logic                mem_resp_i;
    logic [127:0]        mem_rdata_i;
    logic                busy_o;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    always #5 clk_i = ~clk_i;

    dbg_mem_bridge #(
        .DATA_W     (DATA_W),
        .LINE_W     (LINE_W),
        .FIFO_DEPTH (2),
        .TIMEOUT    (8)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .we_i          (we_i),
        .addr_i        (addr_i),
        .be_i          (be_i),
        .wdata_i       (wdata_i),
        .gnt_o         (gnt_o),
        .r_valid_o     (r_valid_o),
        .r_rdata_o     (r_rdata_o),
        .r_err_o       (r_err_o),
        .mem_stb_o     (mem_stb_o),
        .mem_we_o      (mem_we_o),
        .mem_mbe_o     (mem_mbe_o),
        .mem_address_o (mem_address_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_resp_i    (mem_resp_i),
        .mem_rdata_i   (mem_rdata_i),
        .busy_o        (busy_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(negedge clk_i);
    endtask

    initial begin
        rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = 4'hF;
        wdata_i = '0; mem_resp_i = 1'b0; mem_rdata_i = '0;
        #1;
        check("rst_gnt",   gnt_o, 1);
        check("rst_stb",   mem_stb_o, 0);
        check("rst_rv",    r_valid_o, 0);
        check("rst_busy",  busy_o, 0);
        check("rst_addr",  mem_address_o, 0);
        check("rst_mbe",   mem_mbe_o, 0);
        tick; tick; rst_ni = 1'b1; tick;

        // Lane-steered read
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h108; be_i = 4'hF;
        tick; req_i = 1'b0;
        check("t1_stb",  mem_stb_o, 1);
        check("t1_addr", mem_address_o, 32'h100);
        check("t1_mbe",  mem_mbe_o, 16'h0F00);
        check("t1_we",   mem_we_o, 0);
        tick; tick;
        mem_rdata_i = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA; mem_resp_i = 1'b1;
        check("t1_rv_early", r_valid_o, 0);
        tick; mem_resp_i = 1'b0;
        check("t1_rv",    r_valid_o, 1);
        check("t1_rdata", r_rdata_o, 32'hCCCCCCCC);
        check("t1_err",   r_err_o, 0);
        check("t1_stb_off", mem_stb_o, 0);
        tick;
        check("t1_rv_pulse", r_valid_o, 0);
        check("t1_busy", busy_o, 0);

        // Write with replicated data
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h4; be_i = 4'h3; wdata_i = 32'h12345678;
        tick; req_i = 1'b0; we_i = 1'b0;
        check("t2_we",    mem_we_o, 1);
        check("t2_mbe",   mem_mbe_o, 16'h0030);
        check("t2_wdata", mem_wdata_o, 128'h12345678_12345678_12345678_12345678);
        check("t2_addr",  mem_address_o, 32'h0);
        mem_rdata_i = LINE_DATA; mem_resp_i = 1'b1;
        tick; mem_resp_i = 1'b0;
        check("t2_rv",    r_valid_o, 1);
        check("t2_rdata", r_rdata_o, 0);
        check("t2_err",   r_err_o, 0);
        tick;
        check("t2_rv_pulse", r_valid_o, 0);

        // Backpressure and back-to-back responses
        be_i = 4'hF; req_i = 1'b1; addr_i = 32'h0;
        tick;
        check("t3_gnt_one", gnt_o, 1);
        check("t3_a_addr", mem_address_o, 32'h0);
        addr_i = 32'h14;
        tick;
        check("t3_gnt_full", gnt_o, 0);
        addr_i = 32'h28;
        tick;
        check("t3_gnt_hold", gnt_o, 0);
        mem_resp_i = 1'b1;
        tick; mem_resp_i = 1'b0;
        check("t3_a_rv",    r_valid_o, 1);
        check("t3_a_rdata", r_rdata_o, 32'h11111111);
        check("t3_b_stb",   mem_stb_o, 1);
        check("t3_b_addr",  mem_address_o, 32'h10);
        check("t3_gnt_back", gnt_o, 1);
        tick; req_i = 1'b0;
        check("t3_rv_gap", r_valid_o, 0);
        check("t3_b_hold", mem_address_o, 32'h10);
        mem_resp_i = 1'b1;
        tick;
        check("t3_b_rv",    r_valid_o, 1);
        check("t3_b_rdata", r_rdata_o, 32'h22222222);
        check("t3_b2b_stb", mem_stb_o, 1);
        check("t3_c_addr",  mem_address_o, 32'h20);
        tick; mem_resp_i = 1'b0;
        check("t3_c_rv",    r_valid_o, 1);
        check("t3_c_rdata", r_rdata_o, 32'h33333333);
        check("t3_stb_off", mem_stb_o, 0);
        check("t3_busy",    busy_o, 0);
        tick;
        check("t3_rv_pulse", r_valid_o, 0);

        // Timeout on D, then E starts and gets resp in its timeout cycle
        req_i = 1'b1; addr_i = 32'h3C;
        tick; addr_i = 32'h0;
        check("t4_stb_1",  mem_stb_o, 1);
        check("t4_d_addr", mem_address_o, 32'h30);
        tick; req_i = 1'b0;
        check("t4_stb_2", mem_stb_o, 1);
        for (int i = 3; i <= 8; i++) begin
            tick;
            check($sformatf("t4_stb_%0d", i), mem_stb_o, 1);
            check($sformatf("t4_rv_%0d", i), r_valid_o, 0);
        end
        tick;
        check("t4_rv",    r_valid_o, 1);
        check("t4_err",   r_err_o, 1);
        check("t4_rdata", r_rdata_o, 0);
        check("t4_e_stb", mem_stb_o, 1);
        check("t4_e_addr", mem_address_o, 32'h0);
        for (int i = 2; i <= 8; i++) tick;
        check("t5_stb_8", mem_stb_o, 1);
        check("t5_rv_8",  r_valid_o, 0);
        mem_resp_i = 1'b1;
        tick; mem_resp_i = 1'b0;
        check("t5_rv",    r_valid_o, 1);
        check("t5_err",   r_err_o, 0);
        check("t5_rdata", r_rdata_o, 32'h11111111);
        check("t5_stb_off", mem_stb_o, 0);

        // Reset while a transfer is in flight with one queued
        tick;
        req_i = 1'b1; addr_i = 32'h0;
        tick; addr_i = 32'h14;
        tick; req_i = 1'b0;
        check("t6_busy", busy_o, 1);
        check("t6_gnt_full", gnt_o, 0);
        tick;
        rst_ni = 1'b0;
        #1;
        check("t6_stb",  mem_stb_o, 0);
        check("t6_gnt",  gnt_o, 1);
        check("t6_busy_rst", busy_o, 0);
        check("t6_rv",   r_valid_o, 0);
        check("t6_addr", mem_address_o, 0);
        check("t6_mbe",  mem_mbe_o, 0);
        tick; rst_ni = 1'b1;
        mem_resp_i = 1'b1;
        tick; mem_resp_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6_quiet_rv_%0d", i), r_valid_o, 0);
            check($sformatf("t6_quiet_stb_%0d", i), mem_stb_o, 0);
            tick;
        end
        req_i = 1'b1; addr_i = 32'h28;
        tick; req_i = 1'b0;
        check("t6_h_addr", mem_address_o, 32'h20);
        mem_resp_i = 1'b1;
        tick; mem_resp_i = 1'b0;
        check("t6_h_rv",    r_valid_o, 1);
        check("t6_h_rdata", r_rdata_o, 32'h33333333);
        check("t6_h_err",   r_err_o, 0);
        tick;
        check("t6_h_pulse", r_valid_o, 0);
        check("t6_idle",    busy_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
